// File: rtl/regfile_scoreboard_if.sv
// Decode-stage register file bus: read ports, writeback port and load-pending
// scoreboard signals, bundled for the hazard unit and writeback stage.
interface regfile_scoreboard_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic [ADDR_W-1:0] rd_addr1;
    logic [ADDR_W-1:0] rd_addr2;
    logic [DATA_W-1:0] rd_data1;
    logic [DATA_W-1:0] rd_data2;
    logic              rd_pend1;
    logic              rd_pend2;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              pend_set;
    logic [ADDR_W-1:0] pend_addr;
    logic              pend_any;

    modport master (
        output rd_addr1, rd_addr2, wr_en, wr_addr, wr_data, pend_set, pend_addr,
        input  rd_data1, rd_data2, rd_pend1, rd_pend2, pend_any
    );

    modport slave (
        input  rd_addr1, rd_addr2, wr_en, wr_addr, wr_data, pend_set, pend_addr,
        output rd_data1, rd_data2, rd_pend1, rd_pend2, pend_any
    );
endinterface

// File: rtl/regfile_scoreboard.sv
// MIPS register file: two combinational read ports, one write port, optional
// hardwired-zero r0, write-to-read bypass and per-register load-pending bits.
module regfile_scoreboard #(
    parameter int          DATA_W   = 32,
    parameter int          ADDR_W   = 5,
    parameter int unsigned DEPTH    = 32,
    parameter bit          ZERO_REG = 1'b1,
    parameter bit          BYPASS   = 1'b1
) (
    input logic                 clk,
    input logic                 rst_n,
    regfile_scoreboard_if.slave bus
);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DATA_W-1:0] rf_q [DEPTH];
    logic [DEPTH-1:0]  pend_q;
    logic [DEPTH-1:0]  pend_d;
    logic [DEPTH-1:0]  wrVec;
    logic [DEPTH-1:0]  setVec;
    logic              wrValid;
    logic              pendValid;
    logic [IDX_W-1:0]  wrIdx;
    logic [IDX_W-1:0]  pendIdx;
    logic [IDX_W-1:0]  rdIdx1;
    logic [IDX_W-1:0]  rdIdx2;
    logic              fwd1;
    logic              fwd2;
    logic              keep1;
    logic              keep2;

    // Out-of-range addresses and the hardwired zero register behave as if absent.
    function automatic logic addrValid(input logic [ADDR_W-1:0] addr);
        return (32'(addr) < DEPTH) && !(ZERO_REG && (addr == '0));
    endfunction

    always_comb begin
        wrValid   = bus.wr_en && addrValid(bus.wr_addr);
        pendValid = bus.pend_set && addrValid(bus.pend_addr);
        wrIdx     = bus.wr_addr[IDX_W-1:0];
        pendIdx   = bus.pend_addr[IDX_W-1:0];
        wrVec     = wrValid ? (DEPTH'(1) << wrIdx) : '0;
        setVec    = pendValid ? (DEPTH'(1) << pendIdx) : '0;
        // A new load issued in the same cycle as writeback keeps the bit set.
        pend_d    = (pend_q & ~wrVec) | setVec;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                rf_q[i] <= '0;
            end
        end else if (wrValid) begin
            rf_q[wrIdx] <= bus.wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_q <= '0;
        end else begin
            pend_q <= pend_d;
        end
    end

    always_comb begin
        rdIdx1       = bus.rd_addr1[IDX_W-1:0];
        fwd1         = BYPASS && wrValid && (bus.wr_addr == bus.rd_addr1);
        keep1        = pendValid && (bus.pend_addr == bus.rd_addr1);
        bus.rd_data1 = '0;
        bus.rd_pend1 = 1'b0;
        if (addrValid(bus.rd_addr1)) begin
            bus.rd_data1 = fwd1 ? bus.wr_data : rf_q[rdIdx1];
            bus.rd_pend1 = pend_q[rdIdx1] && !(fwd1 && !keep1);
        end
    end

    always_comb begin
        rdIdx2       = bus.rd_addr2[IDX_W-1:0];
        fwd2         = BYPASS && wrValid && (bus.wr_addr == bus.rd_addr2);
        keep2        = pendValid && (bus.pend_addr == bus.rd_addr2);
        bus.rd_data2 = '0;
        bus.rd_pend2 = 1'b0;
        if (addrValid(bus.rd_addr2)) begin
            bus.rd_data2 = fwd2 ? bus.wr_data : rf_q[rdIdx2];
            bus.rd_pend2 = pend_q[rdIdx2] && !(fwd2 && !keep2);
        end
    end

    assign bus.pend_any = |pend_q;
endmodule

// File: tb/tb_regfile_scoreboard.sv
// Self-checking bench for regfile_scoreboard: expected values are queued when
// stimulus is driven and popped when the combinational outputs are sampled.
module tb_regfile_scoreboard;
    logic clk;
    logic rst_n;
    bit   clkRun;

    typedef struct {
        string       name;
        logic [31:0] value;
    } exp_t;

    exp_t        expQ[$];
    exp_t        e;
    int          checks;
    int          passes;
    logic [31:0] mdl [32];

    regfile_scoreboard_if #(.DATA_W(32), .ADDR_W(5)) busA ();
    regfile_scoreboard_if #(.DATA_W(32), .ADDR_W(5)) busB ();
    regfile_scoreboard_if #(.DATA_W(16), .ADDR_W(4)) busC ();

    regfile_scoreboard #(.DATA_W(32), .ADDR_W(5), .DEPTH(32), .ZERO_REG(1'b1), .BYPASS(1'b1))
        dut (.clk(clk), .rst_n(rst_n), .bus(busA));
    regfile_scoreboard #(.DATA_W(32), .ADDR_W(5), .DEPTH(32), .ZERO_REG(1'b1), .BYPASS(1'b0))
        dutNb (.clk(clk), .rst_n(rst_n), .bus(busB));
    regfile_scoreboard #(.DATA_W(16), .ADDR_W(4), .DEPTH(8), .ZERO_REG(1'b1), .BYPASS(1'b1))
        dutSmall (.clk(clk), .rst_n(rst_n), .bus(busC));

    // Gated clock so reset can be exercised with clk parked low.
    initial begin
        clk = 1'b0;
        forever begin
            #5;
            if (clkRun) clk = ~clk;
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic idleAll();
        busA.rd_addr1 = '0; busA.rd_addr2 = '0; busA.wr_en = 1'b0; busA.wr_addr = '0;
        busA.wr_data = '0; busA.pend_set = 1'b0; busA.pend_addr = '0;
        busB.rd_addr1 = '0; busB.rd_addr2 = '0; busB.wr_en = 1'b0; busB.wr_addr = '0;
        busB.wr_data = '0; busB.pend_set = 1'b0; busB.pend_addr = '0;
        busC.rd_addr1 = '0; busC.rd_addr2 = '0; busC.wr_en = 1'b0; busC.wr_addr = '0;
        busC.wr_data = '0; busC.pend_set = 1'b0; busC.pend_addr = '0;
    endtask

    task automatic test_reset();
        clkRun = 1'b0;
        rst_n  = 1'b0;
        idleAll();
        busA.rd_addr1 = 5'd3;
        expQ.push_back('{"reset_rd_data1", 32'h0});
        expQ.push_back('{"reset_pend_any", 32'h0});
        #3;
        e = expQ.pop_front(); checks++;
        if (busA.rd_data1 !== e.value) $display("[TB] FAIL %s: got %h expected %h", e.name, busA.rd_data1, e.value);
        else passes++;
        e = expQ.pop_front(); checks++;
        if (32'(busA.pend_any) !== e.value) $display("[TB] FAIL %s: got %h expected %h", e.name, busA.pend_any, e.value);
        else passes++;
        #1;
        rst_n  = 1'b1;
        clkRun = 1'b1;
    endtask

    task automatic test_write_read();
        @(negedge clk);
        busA.wr_en = 1'b1; busA.wr_addr = 5'd5; busA.wr_data = 32'hDEADBEEF;
        @(negedge clk);
        busA.wr_addr = 5'd0; busA.wr_data = 32'h1;
        busA.rd_addr1 = 5'd5; busA.rd_addr2 = 5'd0;
        expQ.push_back('{"read_r5", 32'hDEADBEEF});
        expQ.push_back('{"r0_no_bypass", 32'h0});
        #1;
        e = expQ.pop_front(); checks++;
        if (busA.rd_data1 !== e.value) $display("[TB] FAIL %s: got %h expected %h", e.name, busA.rd_data1, e.value);
        else passes++;
        e = expQ.pop_front(); checks++;
        if (busA.rd_data2 !== e.value) $display("[TB] FAIL %s: got %h expected %h", e.name, busA.rd_data2, e.value);
        else passes++;
        @(negedge clk);
        busA.wr_en = 1'b0;
        expQ.push_back('{"r0_after_write", 32'h0});
        #1;
        e = expQ.pop_front(); checks++;
        if (busA.rd_data2 !== e.value) $display("[TB] FAIL %s: got %h expected %h", e.name, busA.rd_data2, e.value);
        else passes++;
    endtask

    task automatic test_bypass();
        @(negedge clk);
        busA.wr_en = 1'b1; busA.wr_addr = 5'd7; busA.wr_data = 32'h1234; busA.rd_addr1 = 5'd7;
        busB.wr_en = 1'b1; busB.wr_addr = 5'd7; busB.wr_data = 32'h1234; busB.rd_addr1 = 5'd7;
        expQ.push_back('{"bypass_on", 32'h1234});
        expQ.push_back('{"bypass_off_old", 32'h0});
        #1;
        e = expQ.pop_front(); checks++;
        if (busA.rd_data1 !== e.value) $display("[TB] FAIL %s: got %h expected %h", e.name, busA.rd_data1, e.value);
        else passes++;
        e = expQ.pop_front(); checks++;
        if (busB.rd_data1 !== e.value) $display("[TB] FAIL %s: got %h expected %h", e.name, busB.rd_data1, e.value);
        else passes++;
        @(negedge clk);
        busA.wr_en = 1'b0; busB.wr_en = 1'b0;
        expQ.push_back('{"bypass_off_after_edge", 32'h1234});
        #1;
        e = expQ.pop_front(); checks++;
        if (busB.rd_data1 !== e.value) $display("[TB] FAIL %s: got %h expected %h", e.name, busB.rd_data1, e.value);
        else passes++;
    endtask

    task automatic test_pending();
        @(negedge clk);
        busA.pend_set = 1'b1; busA.pend_addr = 5'd9; busA.rd_addr2 = 5'd9;
        expQ.push_back('{"pend_not_yet", 32'h0});
        #1;
        e = expQ.pop_front(); checks++;
        if (32'(busA.rd_pend2) !== e.value) $display("[TB] FAIL %s: got %h expected %h", e.name, busA.rd_pend2, e.value);
        else passes++;
        @(negedge clk);
        busA.pend_set = 1'b0;
        expQ.push_back('{"pend_r9", 32'h1});
        expQ.push_back('{"pend_any_set", 32'h1});
        #1;
        e = expQ.pop_front(); checks++;
        if (32'(busA.rd_pend2) !== e.value) $display("[TB] FAIL %s: got %h expected %h", e.name, busA.rd_pend2, e.value);
        else passes++;
        e = expQ.pop_front(); checks++;
        if (32'(busA.pend_any) !== e.value) $display("[TB] FAIL %s: got %h expected %h", e.name, busA.pend_any, e.value);
        else passes++;
        @(negedge clk);
        busA.wr_en = 1'b1; busA.wr_addr = 5'd9; busA.wr_data = 32'hA5;
        expQ.push_back('{"pend_cleared_by_bypass", 32'h0});
        expQ.push_back('{"wb_data_bypass", 32'hA5});
        expQ.push_back('{"pend_any_in_wb_cycle", 32'h1});
        #1;
        e = expQ.pop_front(); checks++;
        if (32'(busA.rd_pend2) !== e.value) $display("[TB] FAIL %s: got %h expected %h", e.name, busA.rd_pend2, e.value);
        else passes++;
        e = expQ.pop_front(); checks++;
        if (busA.rd_data2 !== e.value) $display("[TB] FAIL %s: got %h expected %h", e.name, busA.rd_data2, e.value);
        else passes++;
        e = expQ.pop_front(); checks++;
        if (32'(busA.pend_any) !== e.value) $display("[TB] FAIL %s: got %h expected %h", e.name, busA.pend_any, e.value);
        else passes++;
        @(negedge clk);
        busA.wr_en = 1'b0;
        expQ.push_back('{"pend_any_after_wb", 32'h0});
        #1;
        e = expQ.pop_front(); checks++;
        if (32'(busA.pend_any) !== e.value) $display("[TB] FAIL %s: got %h expected %h", e.name, busA.pend_any, e.value);
        else passes++;
    endtask

    task automatic test_set_clear();
        @(negedge clk);
        busA.pend_set = 1'b1; busA.pend_addr = 5'd3;
        busA.wr_en = 1'b1; busA.wr_addr = 5'd3; busA.wr_data = 32'h55; busA.rd_addr1 = 5'd3;
        expQ.push_back('{"setclr_pend_same_cycle", 32'h0});
        #1;
        e = expQ.pop_front(); checks++;
        if (32'(busA.rd_pend1) !== e.value) $display("[TB] FAIL %s: got %h expected %h", e.name, busA.rd_pend1, e.value);
        else passes++;
        @(negedge clk);
        busA.pend_set = 1'b0; busA.wr_en = 1'b0;
        expQ.push_back('{"setclr_data", 32'h55});
        expQ.push_back('{"setclr_pend_wins", 32'h1});
        #1;
        e = expQ.pop_front(); checks++;
        if (busA.rd_data1 !== e.value) $display("[TB] FAIL %s: got %h expected %h", e.name, busA.rd_data1, e.value);
        else passes++;
        e = expQ.pop_front(); checks++;
        if (32'(busA.rd_pend1) !== e.value) $display("[TB] FAIL %s: got %h expected %h", e.name, busA.rd_pend1, e.value);
        else passes++;
        @(negedge clk);
        busA.wr_en = 1'b1; busA.wr_addr = 5'd3; busA.wr_data = 32'h56;
        @(negedge clk);
        busA.wr_en = 1'b0;
        busA.pend_set = 1'b1; busA.pend_addr = 5'd0;
        @(negedge clk);
        busA.pend_set = 1'b0; busA.rd_addr1 = 5'd0;
        expQ.push_back('{"pend_r0_any", 32'h0});
        expQ.push_back('{"pend_r0_read", 32'h0});
        #1;
        e = expQ.pop_front(); checks++;
        if (32'(busA.pend_any) !== e.value) $display("[TB] FAIL %s: got %h expected %h", e.name, busA.pend_any, e.value);
        else passes++;
        e = expQ.pop_front(); checks++;
        if (32'(busA.rd_pend1) !== e.value) $display("[TB] FAIL %s: got %h expected %h", e.name, busA.rd_pend1, e.value);
        else passes++;
    endtask

    task automatic test_small();
        @(negedge clk);
        busC.wr_en = 1'b1; busC.wr_addr = 4'd12; busC.wr_data = 16'hBEEF;
        busC.pend_set = 1'b1; busC.pend_addr = 4'd12; busC.rd_addr1 = 4'd12;
        expQ.push_back('{"small_oob_bypass", 32'h0});
        #1;
        e = expQ.pop_front(); checks++;
        if (32'(busC.rd_data1) !== e.value) $display("[TB] FAIL %s: got %h expected %h", e.name, busC.rd_data1, e.value);
        else passes++;
        @(negedge clk);
        busC.pend_set = 1'b0;
        busC.wr_addr = 4'd7; busC.wr_data = 16'hFFFF; busC.rd_addr2 = 4'd4;
        expQ.push_back('{"small_oob_read", 32'h0});
        expQ.push_back('{"small_no_alias", 32'h0});
        expQ.push_back('{"small_oob_pend", 32'h0});
        #1;
        e = expQ.pop_front(); checks++;
        if (32'(busC.rd_data1) !== e.value) $display("[TB] FAIL %s: got %h expected %h", e.name, busC.rd_data1, e.value);
        else passes++;
        e = expQ.pop_front(); checks++;
        if (32'(busC.rd_data2) !== e.value) $display("[TB] FAIL %s: got %h expected %h", e.name, busC.rd_data2, e.value);
        else passes++;
        e = expQ.pop_front(); checks++;
        if (32'(busC.pend_any) !== e.value) $display("[TB] FAIL %s: got %h expected %h", e.name, busC.pend_any, e.value);
        else passes++;
        @(negedge clk);
        busC.wr_en = 1'b0; busC.rd_addr1 = 4'd7;
        expQ.push_back('{"small_r7", 32'hFFFF});
        #1;
        e = expQ.pop_front(); checks++;
        if (32'(busC.rd_data1) !== e.value) $display("[TB] FAIL %s: got %h expected %h", e.name, busC.rd_data1, e.value);
        else passes++;
    endtask

    task automatic test_random();
        logic [4:0]  a1, a2, wa;
        logic [31:0] wd;
        logic        we;
        mdl[0] = '0;
        for (int r = 1; r < 32; r++) begin
            @(negedge clk);
            busA.wr_en = 1'b1; busA.wr_addr = 5'(r); busA.wr_data = $urandom;
            mdl[r] = busA.wr_data;
        end
        for (int n = 0; n < 24; n++) begin
            @(negedge clk);
            a1 = 5'($urandom_range(0, 31));
            a2 = ($urandom_range(0, 3) == 0) ? a1 : 5'($urandom_range(0, 31));
            we = 1'($urandom_range(0, 1));
            wa = ($urandom_range(0, 1) == 0) ? a1 : 5'($urandom_range(0, 31));
            wd = $urandom;
            busA.rd_addr1 = a1; busA.rd_addr2 = a2;
            busA.wr_en = we; busA.wr_addr = wa; busA.wr_data = wd;
            expQ.push_back('{"rand_rd1", (a1 == 0) ? 32'h0 : (we && wa == a1) ? wd : mdl[a1]});
            expQ.push_back('{"rand_rd2", (a2 == 0) ? 32'h0 : (we && wa == a2) ? wd : mdl[a2]});
            #1;
            e = expQ.pop_front(); checks++;
            if (busA.rd_data1 !== e.value) $display("[TB] FAIL %s: got %h expected %h", e.name, busA.rd_data1, e.value);
            else passes++;
            e = expQ.pop_front(); checks++;
            if (busA.rd_data2 !== e.value) $display("[TB] FAIL %s: got %h expected %h", e.name, busA.rd_data2, e.value);
            else passes++;
            if (we && wa != 0) mdl[wa] = wd;
        end
        @(negedge clk);
        busA.wr_en = 1'b0;
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        busA.pend_set = 1'b1; busA.pend_addr = 5'd12;
        @(negedge clk);
        busA.pend_set = 1'b0;
        busA.wr_en = 1'b1; busA.wr_addr = 5'd20; busA.wr_data = 32'hCAFE;
        clkRun = 1'b0;
        expQ.push_back('{"pend_any_before_reset", 32'h1});
        #1;
        e = expQ.pop_front(); checks++;
        if (32'(busA.pend_any) !== e.value) $display("[TB] FAIL %s: got %h expected %h", e.name, busA.pend_any, e.value);
        else passes++;
        rst_n = 1'b0;
        #1;
        busA.wr_en = 1'b0;
        expQ.push_back('{"pend_any_in_reset", 32'h0});
        #1;
        e = expQ.pop_front(); checks++;
        if (32'(busA.pend_any) !== e.value) $display("[TB] FAIL %s: got %h expected %h", e.name, busA.pend_any, e.value);
        else passes++;
        for (int a = 0; a < 32; a++) begin
            busA.rd_addr1 = 5'(a);
            expQ.push_back('{"reset_clear_rd", 32'h0});
            #1;
            e = expQ.pop_front(); checks++;
            if (busA.rd_data1 !== e.value) $display("[TB] FAIL %s[%0d]: got %h expected %h", e.name, a, busA.rd_data1, e.value);
            else passes++;
        end
        rst_n  = 1'b1;
        clkRun = 1'b1;
        @(negedge clk);
        busA.rd_addr1 = 5'd20;
        expQ.push_back('{"write_lost_in_reset", 32'h0});
        #1;
        e = expQ.pop_front(); checks++;
        if (busA.rd_data1 !== e.value) $display("[TB] FAIL %s: got %h expected %h", e.name, busA.rd_data1, e.value);
        else passes++;
    endtask

    initial begin
        checks = 0;
        passes = 0;
        test_reset();
        test_write_read();
        test_bypass();
        test_pending();
        test_set_clear();
        test_small();
        test_random();
        test_async_reset();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
